// File: rtl/logic_issue.sv
// logic_issue: issue-and-capture controller for a combinational N-bit logical unit.
//   Commands (cmd_a/cmd_b/cmd_op) are accepted on cmd_valid && cmd_ready and
//   registered onto lu_a/lu_b/lu_op. The unit's result lu_r is captured one
//   cycle later into a 2-entry response FIFO. The FIFO head is presented on
//   rsp_r/rsp_zero under a rsp_valid/rsp_ready handshake.
//   busy reports an inflight command or buffered results.
//   Optional macro LOGIC_ISSUE_PARITY_EN adds rsp_parity, the XOR-reduction of
//   rsp_r, which is stored per entry at capture time.
//   clk/reset: rising-edge clock, synchronous active-high reset.
module logic_issue #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [N-1:0] cmd_a,
  input  logic [N-1:0] cmd_b,
  input  logic [1:0]   cmd_op,
  output logic [N-1:0] lu_a,
  output logic [N-1:0] lu_b,
  output logic [1:0]   lu_op,
  input  logic [N-1:0] lu_r,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_r,
  output logic         rsp_zero,
`ifdef LOGIC_ISSUE_PARITY_EN
  output logic         rsp_parity,
`endif
  output logic         busy
);
  logic         inflight, wr_ptr, rd_ptr, accept, pop;
  logic [1:0]   count;
  logic [N-1:0] data [2];
  logic         zf   [2];
`ifdef LOGIC_ISSUE_PARITY_EN
  logic         pf   [2];
`endif
  // Credits count both buffered results and the one still in the unit, so a
  // pop only returns its credit once count has been updated.
  assign cmd_ready = ({1'b0, count} + {2'b00, inflight}) < 3'd2;
  assign rsp_valid = count != 2'd0;
  assign accept    = cmd_valid && cmd_ready;
  assign pop       = rsp_valid && rsp_ready;
  assign busy      = inflight || rsp_valid;
  // Head outputs read as an all-zero result while the FIFO is empty.
  assign rsp_r     = rsp_valid ? data[rd_ptr] : '0;
  assign rsp_zero  = rsp_valid ? zf[rd_ptr] : 1'b1;
`ifdef LOGIC_ISSUE_PARITY_EN
  assign rsp_parity = rsp_valid ? pf[rd_ptr] : 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      lu_a     <= '0;
      lu_b     <= '0;
      lu_op    <= 2'b00;
    end else begin
      if (accept) begin
        lu_a  <= cmd_a;
        lu_b  <= cmd_b;
        lu_op <= cmd_op;
      end
      inflight <= accept;
      if (inflight) wr_ptr <= ~wr_ptr;
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, inflight} - {1'b0, pop};
    end
  end
  // Entry storage needs no reset: it is only observed when count says it is valid.
  always_ff @(posedge clk) begin
    if (!reset && inflight) begin
      data[wr_ptr] <= lu_r;
      zf[wr_ptr]   <= ~|lu_r;
`ifdef LOGIC_ISSUE_PARITY_EN
      pf[wr_ptr]   <= ^lu_r;
`endif
    end
  end
endmodule

// File: tb/tb_logic_issue.sv
// tb_logic_issue: directed bench with a queue-based model of logic_issue.
module tb_logic_issue;
  localparam int N = 32;
  typedef struct {
    logic [N-1:0] r;
    int           vis;
  } ent_t;
  logic         clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, rsp_ready = 1'b1;
  logic [N-1:0] cmd_a = '0, cmd_b = '0;
  logic [1:0]   cmd_op = 2'b00;
  logic         cmd_ready, rsp_valid, rsp_zero, busy;
  logic [N-1:0] lu_a, lu_b, lu_r, rsp_r;
  logic [1:0]   lu_op;
`ifdef LOGIC_ISSUE_PARITY_EN
  logic         rsp_parity;
`endif
  ent_t         q[$];
  logic [N-1:0] got[$];
  logic [N-1:0] m_a = '0, m_b = '0;
  logic [1:0]   m_op = 2'b00;
  int           cyc = 0, checks = 0, fails = 0, n0 = 0;
  bit           started = 0;

  function automatic logic [N-1:0] lu_fn(logic [N-1:0] a, logic [N-1:0] b, logic [1:0] op);
    return op == 2'd0 ? a & b : op == 2'd1 ? a | b : op == 2'd2 ? a ^ b : ~(a | b);
  endfunction

  assign lu_r = lu_fn(lu_a, lu_b, lu_op);

  logic_issue #(.N(N)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .lu_a(lu_a), .lu_b(lu_b), .lu_op(lu_op), .lu_r(lu_r),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_r(rsp_r), .rsp_zero(rsp_zero),
`ifdef LOGIC_ISSUE_PARITY_EN
    .rsp_parity(rsp_parity),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: each accepted command is a queued result that becomes visible at
  // the cycle after its capture; a command holds a credit until popped.
  always @(posedge clk) begin : model
    bit acc, pp;
    acc = !reset && cmd_valid && q.size() < 2;
    pp  = !reset && rsp_ready && q.size() > 0 && q[0].vis <= cyc;
    cyc++;
    started = 1;
    if (reset) begin
      q.delete();
      m_a  = '0;
      m_b  = '0;
      m_op = 2'b00;
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) begin
        q.push_back('{lu_fn(cmd_a, cmd_b, cmd_op), cyc + 1});
        m_a  = cmd_a;
        m_b  = cmd_b;
        m_op = cmd_op;
      end
    end
  end

  always @(negedge clk) begin : compare
    bit mv;
    if (started) begin
      mv = q.size() > 0 && q[0].vis <= cyc;
      chk("cmd_ready", 64'(cmd_ready), 64'(q.size() < 2));
      chk("rsp_valid", 64'(rsp_valid), 64'(mv));
      chk("busy", 64'(busy), 64'(q.size() != 0));
      chk("lu_a", 64'(lu_a), 64'(m_a));
      chk("lu_b", 64'(lu_b), 64'(m_b));
      chk("lu_op", 64'(lu_op), 64'(m_op));
      chk("rsp_r", 64'(rsp_r), mv ? 64'(q[0].r) : 64'd0);
      chk("rsp_zero", 64'(rsp_zero), mv ? 64'(q[0].r == '0) : 64'd1);
`ifdef LOGIC_ISSUE_PARITY_EN
      chk("rsp_parity", 64'(rsp_parity), mv ? 64'(^q[0].r) : 64'd0);
`endif
      if (!reset && rsp_valid && rsp_ready) got.push_back(rsp_r);
    end
  end

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(logic [N-1:0] a, logic [N-1:0] b, logic [1:0] op);
    bit acc;
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    do begin
      acc = cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    cmd_valid = 1'b0;
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", 64'(cmd_ready), 64'd1);
    chk("idle_valid", 64'(rsp_valid), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_op", 64'(lu_op), 64'd0);
    chk("idle_zero", 64'(rsp_zero), 64'd1);
    idle(1);
    send(32'hF0F0F0F0, 32'hFF00FF00, 2'd0);
    @(negedge clk);
    chk("and_lu_a", 64'(lu_a), 64'hF0F0F0F0);
    @(negedge clk);
    chk("and_valid", 64'(rsp_valid), 64'd1);
    chk("and_r", 64'(rsp_r), 64'hF000F000);
    chk("and_zero", 64'(rsp_zero), 64'd0);
    idle(3);
    n0 = got.size();
    send(32'h0000FFFF, 32'h00FF00FF, 2'd1);
    send(32'h0000FFFF, 32'h00FF00FF, 2'd2);
    send(32'h0000FFFF, 32'h00FF00FF, 2'd3);
    idle(6);
    chk("b2b_count", 64'(got.size() - n0), 64'd3);
    chk("b2b_or", 64'(got[n0]), 64'h00FFFFFF);
    chk("b2b_xor", 64'(got[n0+1]), 64'h00FFFF00);
    chk("b2b_nor", 64'(got[n0+2]), 64'hFF000000);
    rsp_ready = 1'b0;
    n0 = got.size();
    send(32'h00000011, 32'h00000101, 2'd1);
    send(32'h00000011, 32'h00000101, 2'd2);
    chk("bp_ready_low", 64'(cmd_ready), 64'd0);
    cmd_valid = 1'b1;
    cmd_a = 32'hA5A5A5A5;
    cmd_b = 32'h0F0F0F0F;
    cmd_op = 2'd0;
    repeat (4) begin
      @(negedge clk);
      chk("bp_hold", 64'(cmd_ready), 64'd0);
    end
    idle(1);
    rsp_ready = 1'b1;
    send(32'hA5A5A5A5, 32'h0F0F0F0F, 2'd0);
    chk("bp_drained", 64'(got.size() - n0), 64'd2);
    chk("bp_first", 64'(got[n0]), 64'h00000111);
    chk("bp_second", 64'(got[n0+1]), 64'h00000110);
    idle(4);
    chk("bp_third", 64'(got[n0+2]), 64'h05050505);
    send(32'h12345678, 32'h12345678, 2'd2);
    @(negedge clk);
    @(negedge clk);
    chk("xor0_valid", 64'(rsp_valid), 64'd1);
    chk("xor0_r", 64'(rsp_r), 64'd0);
    chk("xor0_zero", 64'(rsp_zero), 64'd1);
    idle(3);
    rsp_ready = 1'b0;
    send(32'h0000000F, 32'h000000F0, 2'd1);
    send(32'h00000003, 32'h00000005, 2'd2);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    chk("pre_rst_valid", 64'(rsp_valid), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_lu_a", 64'(lu_a), 64'd0);
    n0 = got.size();
    rsp_ready = 1'b1;
    idle(5);
    chk("rst_no_stale", 64'(got.size() - n0), 64'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
